// File: rtl/polar_encoder_serial.sv
// Serial polar encoder: collects K info bits into the non-frozen u positions,
// runs the F^{(x)n} butterfly one stage per cycle, then streams BPSK beliefs.
module polar_encoder_serial #(
  parameter int           N           = 8,
  parameter int           LOG2N       = 3,
  parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111,
  parameter int           W           = 8,
  parameter int           AMP         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_bit,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [W-1:0] belief_out,
  output logic [LOG2N-1:0]    out_idx,
  input  logic                out_ready,
  output logic                frame_done
);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] ENCODE  = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  function automatic int count_info();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (!FROZEN_MASK[i]) c++;
    end
    return c;
  endfunction

  localparam int K = count_info();
  localparam logic signed [W-1:0] AMP_S = W'(AMP);

  if (K == 0 || N < 2 || N > 64 || (N & (N - 1)) != 0 || (1 << LOG2N) != N ||
      AMP <= 0 || AMP > (1 << (W - 1)) - 1) begin : g_bad_params
    $error("polar_encoder_serial: illegal N/LOG2N/FROZEN_MASK/AMP combination");
  end

  // Bit 0 maps to +AMP, bit 1 to -AMP, matching the decoder's sign convention.
  function automatic logic signed [W-1:0] bpsk_map(input logic b);
    return b ? -AMP_S : AMP_S;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     x_q, x_d;
  logic [LOG2N:0]   cnt_q, cnt_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-1:0] idx_q, idx_d;
  logic [LOG2N-1:0] wr_sel;
  logic [N-1:0]     partner;
  logic [N-1:0]     low_mask;
  int               rank;

  always_comb begin
    // Map the running info-bit count onto the u index it lands in.
    wr_sel = '0;
    rank   = 0;
    for (int i = 0; i < N; i++) begin
      if (!FROZEN_MASK[i]) begin
        if (rank == int'(cnt_q)) wr_sel = LOG2N'(i);
        rank++;
      end
    end
    partner  = x_q >> (1 << stage_q);
    low_mask = '0;
    for (int i = 0; i < N; i++) begin
      low_mask[i] = ((i >> stage_q) & 1) == 0;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          x_d[wr_sel] = in_bit;
          if (cnt_q == (LOG2N + 1)'(K - 1)) begin
            cnt_d   = '0;
            stage_d = '0;
            state_d = ENCODE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ENCODE: begin
        x_d = x_q ^ (partner & low_mask);
        if (stage_q == LOG2N'(LOG2N - 1)) begin
          idx_d   = '0;
          state_d = EMIT;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LOG2N'(N - 1)) begin
            idx_d   = '0;
            x_d     = '0;
            state_d = COLLECT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        x_d     = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      x_q     <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == COLLECT);
    out_valid  = (state_q == EMIT);
    out_idx    = idx_q;
    belief_out = out_valid ? bpsk_map(x_q[idx_q]) : '0;
    frame_done = out_valid && out_ready && (idx_q == LOG2N'(N - 1));
  end

endmodule

// File: tb/tb_polar_encoder_serial.sv
// Directed and model-checked bench for polar_encoder_serial at N=8 and N=32.
module tb_polar_encoder_serial;

  localparam logic [7:0]  MASK_A = 8'b0001_0111;
  localparam logic [31:0] MASK_B = 32'h0117_177F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, in_valid, in_bit, out_ready;
  logic              in_ready, out_valid, frame_done;
  logic signed [7:0] belief_out;
  logic [2:0]        out_idx;

  logic              b_in_valid, b_in_bit, b_out_ready;
  logic              b_in_ready, b_out_valid, b_frame_done;
  logic signed [7:0] b_belief_out;
  logic [4:0]        b_out_idx;

  int n_chk  = 0;
  int n_pass = 0;

  polar_encoder_serial #(.N(8), .LOG2N(3), .FROZEN_MASK(MASK_A), .W(8), .AMP(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .belief_out(belief_out), .out_idx(out_idx),
    .out_ready(out_ready), .frame_done(frame_done));

  polar_encoder_serial #(.N(32), .LOG2N(5), .FROZEN_MASK(MASK_B), .W(8), .AMP(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_bit(b_in_bit), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .belief_out(b_belief_out), .out_idx(b_out_idx),
    .out_ready(b_out_ready), .frame_done(b_frame_done));

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference encoder: x[j] is the XOR of u[i] over every i whose bits cover j.
  function automatic logic [63:0] enc_model(input logic [63:0] u, input int n);
    logic [63:0] x;
    x = '0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  function automatic logic [63:0] place_info(input logic [63:0] mask, input logic [63:0] info,
                                             input int n);
    logic [63:0] u;
    int r;
    u = '0;
    r = 0;
    for (int i = 0; i < n; i++)
      if (!mask[i]) begin
        u[i] = info[r];
        r++;
      end
    return u;
  endfunction

  task automatic send_a(input logic [7:0] bits, input int k);
    for (int i = 0; i < k; i++) begin
      chk($sformatf("a_rdy%0d", i), int'(in_ready), 1);
      in_valid = 1'b1;
      in_bit   = bits[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_a(input logic [7:0] ex, input bit stall, input int stop, input string tag);
    int idx, cyc;
    bit acc, took;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      if (out_valid && idx == stop) begin
        chk({tag, "_stop_idx"}, int'(out_idx), idx);
        chk({tag, "_stop_val"}, int'(belief_out), ex[idx] ? -4 : 4);
        out_ready = 1'b0;
        return;
      end
      acc = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      out_ready = acc;
      #1;
      took = 1'b0;
      if (out_valid) begin
        chk($sformatf("%s_idx%0d", tag, idx), int'(out_idx), idx);
        chk($sformatf("%s_val%0d", tag, idx), int'(belief_out), ex[idx] ? -4 : 4);
        chk($sformatf("%s_done%0d", tag, idx), int'(frame_done), int'(acc && idx == 7));
        chk($sformatf("%s_nrdy%0d", tag, idx), int'(in_ready), 0);
        took = acc;
      end else if (idx > 0) begin
        chk($sformatf("%s_vld_drop%0d", tag, idx), 0, 1);
      end
      @(posedge clk);
      if (took) idx++;
      @(negedge clk);
      cyc++;
    end
    if (stop >= 8) chk({tag, "_timeout"}, idx, 8);
  endtask

  task automatic send_b(input logic [63:0] bits, input int k);
    for (int i = 0; i < k; i++) begin
      chk($sformatf("b_rdy%0d", i), int'(b_in_ready), 1);
      b_in_valid = 1'b1;
      b_in_bit   = bits[i];
      tick();
    end
    b_in_valid = 1'b0;
  endtask

  task automatic recv_b(input logic [31:0] ex, input string tag);
    int idx, cyc;
    bit acc, took;
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 400) begin
      acc = ($urandom_range(0, 3) != 0);
      b_out_ready = acc;
      #1;
      took = 1'b0;
      if (b_out_valid) begin
        chk($sformatf("%s_idx%0d", tag, idx), int'(b_out_idx), idx);
        chk($sformatf("%s_val%0d", tag, idx), int'(b_belief_out), ex[idx] ? -4 : 4);
        chk($sformatf("%s_done%0d", tag, idx), int'(b_frame_done), int'(acc && idx == 31));
        took = acc;
      end
      @(posedge clk);
      if (took) idx++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_timeout"}, idx, 32);
  endtask

  initial begin
    logic [63:0] info, ex;
    int kb;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bit = 1'b0; b_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_belief", int'(belief_out), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    tick();

    // T1 + latency: out_valid low for three cycles, high on the fourth
    send_a(8'h0F, 4);
    chk("lat_c1", int'(out_valid), 0);
    chk("enc_rdy_c1", int'(in_ready), 0);
    tick();
    chk("lat_c2", int'(out_valid), 0);
    tick();
    chk("lat_c3", int'(out_valid), 0);
    chk("enc_rdy_c3", int'(in_ready), 0);
    tick();
    chk("lat_c4", int'(out_valid), 1);
    recv_a(8'h96, 1'b0, 8, "t1");

    send_a(8'h08, 4);
    recv_a(8'hFF, 1'b0, 8, "t2");
    send_a(8'h01, 4);
    recv_a(8'h0F, 1'b0, 8, "t2b");

    send_a(8'h0F, 4);
    recv_a(8'h96, 1'b1, 8, "t3");

    // T4: in_valid stays high with in_bit=1 through ENCODE/EMIT
    send_a(8'h08, 4);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    recv_a(8'hFF, 1'b0, 8, "t4");
    chk("t4_rdy_after", int'(in_ready), 1);
    send_a(8'h01, 4);
    recv_a(8'h0F, 1'b0, 8, "t4b");

    // T5: reset mid-collection discards the partial frame
    send_a(8'h03, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_a(8'h08, 4);
    recv_a(8'hFF, 1'b0, 8, "t5");

    send_a(8'h0F, 4);
    recv_a(8'h96, 1'b0, 3, "t5b");
    rst = 1'b1;
    tick();
    chk("t5b_vld", int'(out_valid), 0);
    chk("t5b_rdy", int'(in_ready), 1);
    chk("t5b_belief", int'(belief_out), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t5b_idle_vld", int'(out_valid), 0);

    for (int f = 0; f < 3; f++) begin
      info = {32'd0, $urandom};
      ex   = enc_model(place_info({56'd0, MASK_A}, info, 8), 8);
      send_a(info[7:0], 4);
      recv_a(ex[7:0], 1'b1, 8, $sformatf("r8f%0d", f));
    end

    kb = 0;
    for (int i = 0; i < 32; i++) if (!MASK_B[i]) kb++;
    for (int f = 0; f < 3; f++) begin
      info = {$urandom, $urandom};
      ex   = enc_model(place_info({32'd0, MASK_B}, info, 32), 32);
      send_b(info, kb);
      recv_b(ex[31:0], $sformatf("r32f%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
